// File: rtl/heq_pixel_mapper_if.sv
// ----------------------------------------------------------------------------
// heq_pixel_mapper_if
// Memory-side bus bundle for the histogram-equalizer pixel mapper.
//   m1ReadAddr / m1ReadBus   : image word read port (synchronous read memory)
//   m2ReadAddr / m2ReadBus   : CDF scratchpad read port (CDF in bits [19:0])
//   m4WriteAddr / m4WriteBus / m4WE : remapped image write port
// Modports: master = mapper side, slave = memory side.
// ----------------------------------------------------------------------------
interface heq_pixel_mapper_if;
   logic [15:0]  m1ReadAddr;
   logic [127:0] m1ReadBus;
   logic [15:0]  m2ReadAddr;
   logic [127:0] m2ReadBus;
   logic [15:0]  m4WriteAddr;
   logic [127:0] m4WriteBus;
   logic         m4WE;

   modport master (
      output m1ReadAddr,
      input  m1ReadBus,
      output m2ReadAddr,
      input  m2ReadBus,
      output m4WriteAddr,
      output m4WriteBus,
      output m4WE
   );

   modport slave (
      input  m1ReadAddr,
      output m1ReadBus,
      input  m2ReadAddr,
      output m2ReadBus,
      input  m4WriteAddr,
      input  m4WriteBus,
      input  m4WE
   );
endinterface

// File: rtl/heq_pixel_mapper.sv
// ----------------------------------------------------------------------------
// heq_pixel_mapper
// Final histogram-equalizer stage. Phase 1 builds a 256-entry remap table
// q(v) = (cdf(v) - cdf_min) * 255 / (N - cdf_min) with an 8-step restoring
// divider (10 cycles per bin). Phase 2 streams every 128-bit image word from
// m1, remaps its 16 pixel lanes through the table and writes them to m4 at
// one word per cycle.
// Ports:
//   clock, rst_n     : system clock, asynchronous active-low reset
//   start            : level enable; dropping it returns to idle
//   cdf_min          : smallest non-zero CDF value
//   inputBaseOffset  : buffer half, address bit 15 for m1 and m4
//   mem              : memory bus bundle (heq_pixel_mapper_if.master)
//   done             : high after the last m4 write until start falls
// Build option: define HEQ_ROUND_EN for round-half-up table entries
// (truncation otherwise); cycle timing is the same in both builds.
// ----------------------------------------------------------------------------
module heq_pixel_mapper #(
   parameter logic [14:0] ADDRESS_OF_LAST = 15'd19199,
   parameter logic [19:0] TOTAL_PIXELS    = 20'd307200,
   parameter int unsigned NUM_BINS        = 256
) (
   input  logic                clock,
   input  logic                rst_n,
   input  logic                start,
   input  logic [19:0]         cdf_min,
   input  logic                inputBaseOffset,
   heq_pixel_mapper_if.master  mem,
   output logic                done
);

   typedef enum logic [2:0] {
      StIdle, StLutReq, StLutLoad, StLutDiv, StMapStream, StMapDrain, StDone
   } state_e;

   state_e       state_q, state_d;
   logic [7:0]   bin_q, bin_d;
   logic [2:0]   k_q, k_d;
   logic [14:0]  word_q, word_d;
   logic [28:0]  rem_q, rem_d;
   logic [19:0]  den_q, den_d;
   logic [7:0]   quo_q, quo_d;
   logic         we_q, we_d;
   logic [15:0]  waddr_q, waddr_d;

   logic         tbl_we;
   logic [7:0]   tbl_wdata;
   logic [7:0]   table_q [NUM_BINS];

   logic [19:0]  c_val, diff, den_now;
   logic [28:0]  num, den_shift;
   logic [15:0]  m1_addr;
   logic [127:0] mapped;
   logic         unused_m2;

   assign c_val     = mem.m2ReadBus[19:0];
   assign unused_m2 = ^mem.m2ReadBus[127:20];
   assign diff      = (c_val < cdf_min) ? 20'd0 : c_val - cdf_min;
   assign den_now   = TOTAL_PIXELS - cdf_min;
`ifdef HEQ_ROUND_EN
   assign num       = {9'd0, diff} * 29'd255 + {10'd0, den_now[19:1]};
`else
   assign num       = {9'd0, diff} * 29'd255;
`endif
   assign den_shift = {9'd0, den_q} << k_q;
   assign m1_addr   = (state_q == StMapStream) ? {inputBaseOffset, word_q} : 16'd0;

   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      k_d       = k_q;
      word_d    = word_q;
      rem_d     = rem_q;
      den_d     = den_q;
      quo_d     = quo_q;
      we_d      = 1'b0;
      waddr_d   = waddr_q;
      tbl_we    = 1'b0;
      tbl_wdata = quo_q;
      if (!start) begin
         state_d = StIdle;
         bin_d   = 8'd0;
         k_d     = 3'd0;
         word_d  = 15'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               bin_d   = 8'd0;
               state_d = StLutReq;
            end
            StLutReq: state_d = StLutLoad;
            StLutLoad: begin
               den_d   = den_now;
               rem_d   = num;
               quo_d   = 8'd0;
               k_d     = 3'd7;
               state_d = StLutDiv;
            end
            StLutDiv: begin
               // den == 0 leaves q at 0 but still spends the full 8 cycles
               if ((den_q != 20'd0) && (rem_q >= den_shift)) begin
                  rem_d        = rem_q - den_shift;
                  quo_d[k_q]   = 1'b1;
               end
               k_d = k_q - 3'd1;
               if (k_q == 3'd0) begin
                  tbl_we    = 1'b1;
                  tbl_wdata = quo_d;
                  if (bin_q == 8'(NUM_BINS - 1)) begin
                     word_d  = 15'd0;
                     state_d = StMapStream;
                  end else begin
                     bin_d   = bin_q + 8'd1;
                     state_d = StLutReq;
                  end
               end
            end
            StMapStream: begin
               // write strobe/address trail the read by the memory latency
               we_d    = 1'b1;
               waddr_d = m1_addr;
               word_d  = word_q + 15'd1;
               if (word_q == ADDRESS_OF_LAST) state_d = StMapDrain;
            end
            StMapDrain: state_d = StDone;
            StDone:     state_d = StDone;
            default:    state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         bin_q   <= 8'd0;
         k_q     <= 3'd0;
         word_q  <= 15'd0;
         rem_q   <= 29'd0;
         den_q   <= 20'd0;
         quo_q   <= 8'd0;
         we_q    <= 1'b0;
         waddr_q <= 16'd0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         k_q     <= k_d;
         word_q  <= word_d;
         rem_q   <= rem_d;
         den_q   <= den_d;
         quo_q   <= quo_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
      end
   end

   // Table contents are rebuilt before every use, so no reset is needed.
   always_ff @(posedge clock) begin
      if (tbl_we) table_q[bin_q] <= tbl_wdata;
   end

   always_comb begin
      mapped = '0;
      for (int k = 0; k < 16; k++) begin
         mapped[8*k +: 8] = table_q[mem.m1ReadBus[8*k +: 8]];
      end
   end

   assign mem.m1ReadAddr  = m1_addr;
   assign mem.m2ReadAddr  = {8'd0, bin_q};
   assign mem.m4WE        = we_q;
   assign mem.m4WriteAddr = waddr_q;
   assign mem.m4WriteBus  = we_q ? mapped : 128'd0;
   assign done            = (state_q == StDone);

endmodule

// File: tb/tb_heq_pixel_mapper.sv
module tb_heq_pixel_mapper;

   localparam int NWORDS     = 19200;
   localparam int RUN_CYCLES = 2560 + 19200 + 2;
   localparam longint TOTAL  = 307200;
`ifdef HEQ_ROUND_EN
   localparam bit ROUND = 1'b1;
`else
   localparam bit ROUND = 1'b0;
`endif

   logic        clock;
   logic        rst_n;
   logic        start;
   logic [19:0] cdf_min;
   logic        inputBaseOffset;
   logic        done;

   heq_pixel_mapper_if mem_if ();

   heq_pixel_mapper dut (
      .clock           (clock),
      .rst_n           (rst_n),
      .start           (start),
      .cdf_min         (cdf_min),
      .inputBaseOffset (inputBaseOffset),
      .mem             (mem_if),
      .done            (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int kind   = 0;

   // kind 0: uniform 37; kind 1: half 0 / half 255; kind 2: mixed bins around cdf_min
   function automatic logic [19:0] cdf_val(input int k, input int v);
      case (k)
         0:       return (v >= 37) ? 20'd307200 : 20'd0;
         1:       return (v == 255) ? 20'd307200 : 20'd153600;
         default: begin
            if (v < 5) return 20'd0;
            if (v < 9) return 20'd100000;
            if (v == 9) return 20'd203600;
            return 20'd307200;
         end
      endcase
   endfunction

   function automatic logic [127:0] img_word(input int k, input logic [14:0] w);
      logic [127:0] r;
      r = '0;
      for (int l = 0; l < 16; l++) begin
         case (k)
            0:       r[8*l +: 8] = 8'd37;
            1:       r[8*l +: 8] = l[0] ? 8'd255 : 8'd0;
            default: r[8*l +: 8] = 8'((int'(w) + l) % 16);
         endcase
      end
      return r;
   endfunction

   // synchronous-read memory models
   always @(posedge clock) begin
      mem_if.m1ReadBus <= img_word(kind, mem_if.m1ReadAddr[14:0]);
      mem_if.m2ReadBus <= {108'd0, cdf_val(kind, int'(mem_if.m2ReadAddr[7:0]))};
   end

   typedef struct {
      logic [15:0]  addr;
      logic [127:0] data;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      string       name;
      int          kind;
      logic [19:0] cmin;
      logic        off;
      int          la;
      logic [7:0]  ea;
      int          lb;
      logic [7:0]  eb;
   } vec_t;
   vec_t vecs[3];

   logic [7:0]   exp_tbl [256];
   int           pulses, sb_bad, trk_bad;
   logic [15:0]  prev_m1, last_addr;
   logic [127:0] first_word;
   bit           first_seen;

   // write-port monitor and scoreboard consumer
   initial begin
      prev_m1 = '0;
      forever begin
         @(negedge clock);
         if (mem_if.m4WE === 1'b1) begin
            pulses++;
            if (!first_seen) begin
               first_word = mem_if.m4WriteBus;
               first_seen = 1'b1;
            end
            last_addr = mem_if.m4WriteAddr;
            if (mem_if.m4WriteAddr !== prev_m1) trk_bad++;
            if (sb_q.size() == 0) sb_bad++;
            else begin
               sb_t e;
               e = sb_q.pop_front();
               if (e.addr !== mem_if.m4WriteAddr || e.data !== mem_if.m4WriteBus) sb_bad++;
            end
         end
         prev_m1 = mem_if.m1ReadAddr;
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic prep(input vec_t v);
      longint c, den, diff, num;
      kind            = v.kind;
      cdf_min         = v.cmin;
      inputBaseOffset = v.off;
      den = TOTAL - longint'(v.cmin);
      for (int b = 0; b < 256; b++) begin
         c    = longint'(cdf_val(v.kind, b));
         diff = (c < longint'(v.cmin)) ? 0 : c - longint'(v.cmin);
         num  = diff * 255 + (ROUND ? den / 2 : 0);
         exp_tbl[b] = (den == 0) ? 8'd0 : 8'(num / den);
      end
      sb_q.delete();
      for (int w = 0; w < NWORDS; w++) begin
         sb_t e;
         logic [127:0] px;
         px     = img_word(v.kind, 15'(w));
         e.addr = {v.off, 15'(w)};
         for (int l = 0; l < 16; l++) e.data[8*l +: 8] = exp_tbl[px[8*l +: 8]];
         sb_q.push_back(e);
      end
      pulses = 0; sb_bad = 0; trk_bad = 0; first_seen = 1'b0; last_addr = '0;
   endtask

   task automatic run_full(input vec_t v);
      int n;
      bit got;
      prep(v);
      @(negedge clock);
      start = 1'b1;
      n = 0; got = 1'b0;
      for (int i = 0; i < 30000; i++) begin
         @(posedge clock);
         #1;
         n++;
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      check({v.name, "_done_seen"}, 128'(got), 128'd1);
      check({v.name, "_done_cycles"}, 128'(n), 128'(RUN_CYCLES));
      check({v.name, "_we_pulses"}, 128'(pulses), 128'(NWORDS));
      check({v.name, "_sb_mismatch"}, 128'(sb_bad), 128'd0);
      check({v.name, "_sb_left"}, 128'(sb_q.size()), 128'd0);
      check({v.name, "_addr_track"}, 128'(trk_bad), 128'd0);
      check({v.name, "_last_addr"}, 128'(last_addr), 128'({v.off, 15'd19199}));
      check({v.name, "_probe_a"}, 128'(first_word[8*v.la +: 8]), 128'(v.ea));
      check({v.name, "_probe_b"}, 128'(first_word[8*v.lb +: 8]), 128'(v.eb));
      check({v.name, "_we_done"}, 128'(mem_if.m4WE), 128'd0);
      @(negedge clock);
      start = 1'b0;
      @(posedge clock);
      #1;
      check({v.name, "_done_clear"}, 128'(done), 128'd0);
   endtask

   initial begin
      bit found;
      vecs[0] = '{"uniform37", 0, 20'd307200, 1'b0, 0, 8'd0, 15, 8'd0};
      vecs[1] = '{"half", 1, 20'd153600, 1'b0, 15, 8'd255, 0, 8'd0};
      vecs[2] = '{"round", 2, 20'd100000, 1'b1, 9, (ROUND ? 8'd128 : 8'd127), 3, 8'd0};

      rst_n = 1'b0; start = 1'b0; cdf_min = '0; inputBaseOffset = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_m1addr", 128'(mem_if.m1ReadAddr), 128'd0);
      check("rst_m2addr", 128'(mem_if.m2ReadAddr), 128'd0);
      check("rst_m4addr", 128'(mem_if.m4WriteAddr), 128'd0);
      check("rst_m4bus", mem_if.m4WriteBus, 128'd0);
      check("rst_m4we", 128'(mem_if.m4WE), 128'd0);
      check("rst_done", 128'(done), 128'd0);
      rst_n = 1'b1;

      // abort mid-stream at word 5000
      prep(vecs[1]);
      @(negedge clock);
      start = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 30000; i++) begin
         @(negedge clock);
         if (mem_if.m1ReadAddr == 16'd5000) begin
            found = 1'b1;
            break;
         end
      end
      check("abort_reached", 128'(found), 128'd1);
      start = 1'b0;
      @(posedge clock);
      #1;
      check("abort_we", 128'(mem_if.m4WE), 128'd0);
      check("abort_done", 128'(done), 128'd0);
      repeat (3) @(posedge clock);
      #1;
      check("abort_idle_m1", 128'(mem_if.m1ReadAddr), 128'd0);
      check("abort_idle_bin", 128'(mem_if.m2ReadAddr), 128'd0);
      check("abort_done_hold", 128'(done), 128'd0);
      check("abort_pulses", 128'(pulses), 128'd5000);
      check("abort_sb", 128'(sb_bad), 128'd0);
      check("abort_track", 128'(trk_bad), 128'd0);

      // restart runs from bin 0, then async reset lands inside LUT_DIV of bin 1
      @(negedge clock);
      start = 1'b1;
      repeat (12) @(posedge clock);
      #1;
      check("rerun_bin1", 128'(mem_if.m2ReadAddr), 128'd1);
      check("rerun_no_we", 128'(mem_if.m4WE), 128'd0);
      repeat (4) @(posedge clock);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_m2addr", 128'(mem_if.m2ReadAddr), 128'd0);
      check("arst_m4addr", 128'(mem_if.m4WriteAddr), 128'd0);
      check("arst_m4we", 128'(mem_if.m4WE), 128'd0);
      check("arst_done", 128'(done), 128'd0);
      start = 1'b0;
      repeat (2) @(negedge clock);
      rst_n = 1'b1;

      for (int i = 0; i < 3; i++) run_full(vecs[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/heq_pixel_mapper.md
Name: heq_pixel_mapper

Overview:
- Final stage of the histogram equalizer; sits directly downstream of the input/CDF stage.
- Starts once the CDF is valid in scratchpad m2. Phase 1 builds a 256-entry 8-bit remap table from the CDF using a sequential divider.
- Phase 2 streams every 128-bit image word from m1 (16 x 8-bit pixels), remaps each pixel through the table, and writes the result to output memory m4.

Parameters:
- ADDRESS_OF_LAST, 15'd19199, word index of the last image word (640x480 image / 16 pixels per word).
- TOTAL_PIXELS, 20'd307200, pixel count N used as the CDF maximum.
- NUM_BINS, 256, remap table depth (one entry per 8-bit pixel value).

Ports:
- clock, input, 1, single system clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, level enable driven from CDF-stage cdf_valid/done; dropping it aborts the operation.
- cdf_min, input, 20, smallest non-zero CDF value, held stable while start is high.
- inputBaseOffset, input, 1, selects the buffer half; used as address bit 15 for m1 and m4.
- m1ReadAddr, output, 16, image read address {inputBaseOffset, wordIdx}.
- m1ReadBus, input, 128, image word; pixel k is bits [8k+7:8k].
- m2ReadAddr, output, 16, scratchpad address = bin value v (0..255) during phase 1.
- m2ReadBus, input, 128, CDF of bin v in bits [19:0]; other bits ignored.
- m4WriteAddr, output, 16, {inputBaseOffset, wordIdx}.
- m4WriteBus, output, 128, remapped pixels in the same lane order as m1.
- m4WE, output, 1, write strobe for m4.
- done, output, 1, high after the last m4 write; held until start falls.

Behaviour:
- Memories: synchronous read, data valid the cycle after the address is presented.
- Reset values: all addresses 0, m4WriteBus 0, m4WE 0, done 0; FSM in IDLE; table contents are don't-care.
- start low in any state: next cycle go to IDLE, clear m4WE, done and counters. No partial write is completed after start drops.
- States:
  - IDLE: if start, set bin=0 and go to LUT_REQ.
  - LUT_REQ: drive m2ReadAddr=bin for one cycle, then go to LUT_LOAD.
  - LUT_LOAD: capture c=m2ReadBus[19:0]; set den=TOTAL_PIXELS-cdf_min; set diff=(c<cdf_min)?0:c-cdf_min; set num=diff*255 (+ rounding term, see Optional Feature, 29-bit). Go to LUT_DIV.
  - LUT_DIV: 8 cycles, restoring division MSB-first. For k=7..0: if rem>=den<<k then rem-=den<<k and q[k]=1. Then write table[bin]=q.
    - If den==0, q=0 with no divide; the state still takes 8 cycles.
    - If bin==255, go to MAP_STREAM with wordIdx=0; otherwise bin+1 and go to LUT_REQ.
    - Phase 1 length: exactly 256x10 = 2560 cycles.
  - MAP_STREAM: issue m1ReadAddr={inputBaseOffset,wordIdx} every cycle and increment wordIdx.
    - One cycle later, m4WriteBus lane k = table[m1ReadBus lane k], m4WE=1, m4WriteAddr equals the address of that read.
    - Throughput: 1 word/cycle.
    - After wordIdx==ADDRESS_OF_LAST is issued, go to MAP_DRAIN.
  - MAP_DRAIN: the last write occurs, then go to DONE.
  - DONE: m4WE=0, done=1; stay until start falls.
- Address latency: m4WriteAddr = the m1ReadAddr issued 1 cycle earlier. Exactly 19200 m4WE pulses per run, with no gaps or duplicates.
- Quotient is at most 255 by construction (diff<=den); no saturation logic needed.
- A cdf_min change mid-run is not supported; the result is undefined.

Optional Feature:
- Macro: HEQ_ROUND_EN.
- Defined: num = diff*255 + (den>>1), giving round-half-up.
- Undefined: num = diff*255, giving truncation.
- Cycle timing is identical in both builds.

Test Plan:
- Uniform image, all pixels 37; cdf(v)=307200 for v>=37; cdf_min=307200 -> den=0, all 19200 m4 words = 0, done after 2560+19200+2 cycles from start.
- Half pixels 0, half 255; cdf(0)=153600, cdf(255)=307200; cdf_min=153600 -> pixel 0 maps to 0, pixel 255 maps to 255, lane order preserved.
- cdf_min=100000, cdf(9)=203600 (diff=103600, exact quotient 127.5) -> table[9]=128 with HEQ_ROUND_EN, 127 without.
- Bins below the min bin with cdf=0 < cdf_min -> map to 0. Check m4WriteAddr tracks m1ReadAddr+1-cycle with inputBaseOffset=1 (addresses 0x8000..0xCAFF).
- Deassert start mid MAP_STREAM at word 5000 -> m4WE=0 next cycle, FSM in IDLE, done stays 0. Reassert -> full rerun from bin 0.
- Pulse rst_n low during LUT_DIV -> all outputs at reset values immediately (asynchronous), then a clean full run.
